// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the ID/EX stage and the ALU.
//   OP_W    : ALU operation code width
//   alu_op_e: legal ALU opcodes. They occupy a contiguous range starting at 0,
//             so "legal" is the same as "op <= OP_SHR".
package alu_pkg;
  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_SHL = 4'b0100,
    OP_SHR = 4'b0101
  } alu_op_e;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux -- operand source select for one register operand.
//   i_rs / i_rs_data          : register index and register-file read data
//   i_mem_we/_rd/_data        : EX/MEM bypass source
//   i_wb_we/_rd/_data         : MEM/WB bypass source
//   o_data                    : resolved operand
// Macro ID_EX_FORWARD_EN: when defined, bypass from EX/MEM (higher priority)
// then MEM/WB; otherwise the register-file data is used directly. x0 always
// resolves to 0, and a bypass targeting x0 never matches.
module fwd_mux #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        i_rs,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic              i_mem_we,
  input  logic [4:0]        i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data
);
`ifdef ID_EX_FORWARD_EN
  always_comb begin
    o_data = i_rs_data;
    if (i_rs == 5'd0)                           o_data = '0;
    else if (i_mem_we && (i_mem_rd == i_rs))    o_data = i_mem_data;
    else if (i_wb_we  && (i_wb_rd  == i_rs))    o_data = i_wb_data;
  end
`else
  // Bypass inputs stay on the port list so the stage interface does not
  // change with the build option.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_mem_we, i_mem_rd, i_mem_data, i_wb_we, i_wb_rd, i_wb_data};

  always_comb begin
    o_data = i_rs_data;
    if (i_rs == 5'd0) o_data = '0;
  end
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand bypass.
//   clk, reset             : clock, synchronous active-high reset
//   in_valid/in_ready      : decode-side handshake
//   in_op, in_rs1/2, in_rd : opcode and register indices
//   in_rs1/2_data, in_imm, in_use_imm : register data, immediate, op2 select
//   fwd_mem_*, fwd_wb_*    : bypass sources (used only with ID_EX_FORWARD_EN)
//   flush                  : drop held and incoming instruction
//   out_valid/out_ready    : ALU-side handshake
//   out_op/operand1/operand2/rd, out_illegal, out_div_zero : registered ALU inputs
//   stall_count            : saturating count of back-pressure cycles
// Macro ID_EX_FORWARD_EN enables the bypass network.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic              fwd_mem_we,
  input  logic [4:0]        fwd_mem_rd,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_we,
  input  logic [4:0]        fwd_wb_rd,
  input  logic [DATA_W-1:0] fwd_wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_operand1,
  output logic [DATA_W-1:0] out_operand2,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic              out_div_zero,
  output logic [15:0]       stall_count
);
  logic              r_valid;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_opnd1, r_opnd2;
  logic [4:0]        r_rd;
  logic              r_illegal, r_div_zero;
  logic [15:0]       r_stall;

  logic [DATA_W-1:0] w_rs1_val, w_rs2_val, w_opnd2;
  logic              w_capture, w_illegal, w_div_zero;

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs1 (
    .i_rs(in_rs1), .i_rs_data(in_rs1_data),
    .i_mem_we(fwd_mem_we), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_we(fwd_wb_we), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_data(w_rs1_val)
  );

  fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs2 (
    .i_rs(in_rs2), .i_rs_data(in_rs2_data),
    .i_mem_we(fwd_mem_we), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_we(fwd_wb_we), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_data(w_rs2_val)
  );

  assign in_ready   = !flush && (!r_valid || out_ready);
  assign w_capture  = in_valid && in_ready;
  assign w_opnd2    = in_use_imm ? in_imm : w_rs2_val;
  // Legal opcodes are the contiguous range ADD..SHR.
  assign w_illegal  = (in_op > OP_W'(alu_pkg::OP_SHR));
  assign w_div_zero = (in_op == OP_W'(alu_pkg::OP_DIV)) && (w_opnd2 == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_op       <= '0;
      r_opnd1    <= '0;
      r_opnd2    <= '0;
      r_rd       <= '0;
      r_illegal  <= 1'b0;
      r_div_zero <= 1'b0;
      r_stall    <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid    <= 1'b1;
        r_op       <= in_op;
        r_opnd1    <= w_rs1_val;
        r_opnd2    <= w_opnd2;
        r_rd       <= in_rd;
        r_illegal  <= w_illegal;
        r_div_zero <= w_div_zero;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end

      if (r_valid && !out_ready && !flush && (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
    end
  end

  assign out_valid    = r_valid;
  assign out_op       = r_op;
  assign out_operand1 = r_opnd1;
  assign out_operand2 = r_opnd2;
  assign out_rd       = r_rd;
  assign out_illegal  = r_illegal;
  assign out_div_zero = r_div_zero;
  assign stall_count  = r_stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver pushes hand-computed expected
// outputs, a negedge monitor pops and compares on every ALU-side transfer.
module tb_id_ex_stage;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_use_imm, flush;
  logic [3:0]  in_op;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        fwd_mem_we, fwd_wb_we;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready, out_illegal, out_div_zero;
  logic [3:0]  out_op;
  logic [31:0] out_operand1, out_operand2;
  logic [4:0]  out_rd;
  logic [15:0] stall_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_operand1(out_operand1), .out_operand2(out_operand2),
    .out_rd(out_rd), .out_illegal(out_illegal), .out_div_zero(out_div_zero),
    .stall_count(stall_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t cur_out();
    exp_t o;
    o = '{op: out_op, a: out_operand1, b: out_operand2, rd: out_rd,
          ill: out_illegal, dz: out_div_zero};
    return o;
  endfunction

  // Monitor: a transfer happens at the next posedge whenever valid&&ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !flush) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_transfer", cur_out(), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                      input logic use_imm, input logic [31:0] imm,
                      input logic [31:0] ea, input logic [31:0] eb,
                      input logic eill, input logic edz, input logic push);
    exp_t e;
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_use_imm = use_imm; in_imm = imm;
    in_valid = 1'b1;
    e = '{op: op, a: ea, b: eb, rd: rd, ill: eill, dz: edz};
    if (push) sb_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    exp_t held;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_use_imm = 1'b0;
    fwd_mem_we = 1'b0; fwd_mem_rd = '0; fwd_mem_data = '0;
    fwd_wb_we = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;
    // Incoming valid during reset must be ignored.
    in_valid = 1'b1; in_rs1_data = 32'hDEAD;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outputs", cur_out(), '0);
    chk("reset_stall_count", stall_count, 0);
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Basic add, no bypass.
    send(4'b0000, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 1'b0, 32'd0, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1);

    // Both bypass sources match rs1: EX/MEM wins.
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hAA;
    fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd3; fwd_wb_data  = 32'hBB;
`ifdef ID_EX_FORWARD_EN
    send(4'b0001, 5'd3, 5'd5, 5'd9, 32'h11, 32'h22, 1'b0, 32'd0, 32'hAA, 32'h22, 1'b0, 1'b0, 1'b1);
`else
    send(4'b0001, 5'd3, 5'd5, 5'd9, 32'h11, 32'h22, 1'b0, 32'd0, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1);
`endif

    // rs1 from MEM/WB only, rs2 from EX/MEM.
    fwd_mem_rd = 5'd7; fwd_mem_data = 32'hDD;
    fwd_wb_rd  = 5'd6; fwd_wb_data  = 32'hCC;
`ifdef ID_EX_FORWARD_EN
    send(4'b0100, 5'd6, 5'd7, 5'd1, 32'h33, 32'h44, 1'b0, 32'd0, 32'hCC, 32'hDD, 1'b0, 1'b0, 1'b1);
`else
    send(4'b0100, 5'd6, 5'd7, 5'd1, 32'h33, 32'h44, 1'b0, 32'd0, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1);
`endif

    // x0 operands: never bypassed, always 0.
    fwd_mem_rd = 5'd0; fwd_mem_data = 32'h55;
    fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'h66;
    send(4'b0010, 5'd0, 5'd0, 5'd2, 32'h77, 32'h99, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;

    // Divide by immediate zero, divide by nonzero immediate, illegal op.
    send(4'b0011, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 1'b1, 32'd0, 32'd8, 32'd0, 1'b0, 1'b1, 1'b1);
    send(4'b0011, 5'd1, 5'd2, 5'd3, 32'd8, 32'd9, 1'b1, 32'd3, 32'd8, 32'd3, 1'b0, 1'b0, 1'b1);
    send(4'b0111, 5'd1, 5'd2, 5'd5, 32'd4, 32'd6, 1'b0, 32'd0, 32'd4, 32'd6, 1'b1, 1'b0, 1'b1);
    send(4'b0101, 5'd1, 5'd2, 5'd5, 32'd4, 32'd0, 1'b0, 32'd0, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1);
    tick();  // drain last entry
    chk("drained_valid", out_valid, 0);
    chk("stall_before_bp", stall_count, 0);

    // Back-pressure: hold for 3 cycles, then flush.
    out_ready = 1'b0;
    send(4'b0001, 5'd8, 5'd9, 5'd10, 32'h123, 32'h456, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    held = '{op: 4'b0001, a: 32'h123, b: 32'h456, rd: 5'd10, ill: 1'b0, dz: 1'b0};
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    // A competing instruction is offered while stalled; it must not load.
    in_valid = 1'b1; in_op = 4'b0010; in_rs1_data = 32'hFFFF; in_rd = 5'd30;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("bp_hold", cur_out(), held);
      chk("bp_in_ready_hold", in_ready, 0);
    end
    chk("bp_stall_count", stall_count, 3);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_clears_valid", out_valid, 0);
    chk("flush_no_stall_count", stall_count, 3);
    out_ready = 1'b1;
    #1;
    chk("in_ready_after_flush", in_ready, 1);

    repeat (2) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end
endmodule
